mfm_encoder: RTL
================

MFM_ENCODER -- requirements
Module: mfm_encoder

Interface
REQ-001 SHALL have parameter: GAP_BYTE, 8'h4E, byte encoded when no data byte is available at a byte boundary.
REQ-002 SHALL have port: clk5  input  1  MFM cell clock; one MFM cell per rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: enable  input  1  encoder run; low = idle.
REQ-005 SHALL have port: byte_in  input  8  data byte, MSB encoded first.
REQ-006 SHALL have port: byte_sync  input  1  byte_in is an address mark; qualified by byte_valid.
REQ-007 SHALL have port: byte_valid  input  1  byte_in/byte_sync valid.
REQ-008 SHALL have port: byte_ready  output  1  encoder can accept a byte this cycle.
REQ-009 SHALL have port: mfm_out  output  1  registered MFM cell stream to the track buffer.
REQ-010 SHALL have port: loaded  output  1  one-cycle pulse: a data byte (not gap) entered the shifter.
REQ-011 SHALL have port: underrun  output  1  sticky: a gap byte was inserted while enabled.
REQ-012 SHALL use one clock, clk5; reset SHALL be synchronous and active-high on port reset.

Function
REQ-013 SHALL encode each byte as 16 consecutive cells, per bit MSB-first: clock cell, then data cell.
REQ-014 SHALL drive data cell = data bit; clock cell = NOT(prev) AND NOT(cur), with prev = last data bit emitted, carried across byte boundaries.
REQ-015 SHALL force the clock cell of bit 2 (LSB = bit 0) to 0 when the byte was accepted with byte_sync=1 (0xA1 -> 0x4489).
REQ-016 SHALL hold a 4-bit cell counter; counter value k = cell k of the current byte is on mfm_out; even = clock cell, odd = data cell.
REQ-017 SHALL perform a load edge when enable=1 and counter=15: the shifter loads, counter goes to 0, and mfm_out shows the bit-7 clock cell after that same edge.
REQ-018 SHALL contain a one-entry holding register (byte + sync flag); byte_ready = holding register empty OR (load edge this cycle AND holding register full).
REQ-019 SHALL accept a byte on any edge with byte_valid AND byte_ready; an accept with byte_valid low SHALL NOT occur.
REQ-020 SHALL, at a load edge: load the holding register if full; else if a byte is accepted on that edge, load it directly (bypass, holding register stays empty); else load GAP_BYTE with sync flag 0.
REQ-021 SHALL pulse loaded for exactly the one cycle after a data-byte load edge; never for a gap load.
REQ-022 SHALL set underrun on every gap load; it SHALL clear only on reset.
REQ-023 SHALL, while enable=0: drive mfm_out 0, hold counter at 15, hold prev at 0, pulse no loaded, keep accepting into the holding register; the first edge with enable=1 SHALL be a load edge.
REQ-024 SHALL ignore byte_in/byte_sync when byte_valid=0.
REQ-025 SHALL, when enable drops mid-byte, abandon the remaining cells of that byte on the next edge.

Reset
REQ-026 SHALL, on reset, set mfm_out=0, loaded=0, underrun=0, counter=15, prev=0, holding register empty, byte_ready=1.
REQ-027 SHALL let reset override all other inputs including an accept on the same edge; a byte offered on the reset edge SHALL be discarded.
REQ-028 SHALL, on reset mid-byte, stop the byte immediately; mfm_out=0 after the reset edge.

Verification
REQ-029 SHALL cover: reset, enable=1, offer 0xA1 with byte_sync=1 before the first load edge -> 16 cells 0100010010001001 (0x4489), loaded pulse once.
REQ-030 SHALL cover: same with byte_sync=0 -> 0100010010101001 (0x44A9).
REQ-031 SHALL cover: reset, enable=1, byte_valid=0 -> cells 1001001001010100 (0x9254, GAP 0x4E with prev=0), underrun=1, loaded stays 0.
REQ-032 SHALL cover: byte_valid held high, 0x00 then 0xFF, from reset -> 0xAAAA then 0x5555 with no gap between; loaded pulses 16 cycles apart; underrun stays 0.
REQ-033 SHALL cover: reset asserted at cell 7 of a byte with holding register full -> mfm_out=0, byte_ready=1, underrun=0 after the edge; that byte is never emitted.
REQ-034 SHALL cover: enable=0, offer 0x5A -> accepted, byte_ready=0, mfm_out=0; raise enable -> 0x5A cells begin after the next edge, byte_ready returns to 1.

Source files
------------

// File: rtl/mfm_encoder.sv
// MFM cell encoder: turns a byte stream into 16 MFM cells per byte, MSB first,
// with address-mark clock suppression and gap-byte fill when the source runs dry.
module mfm_encoder #(
  parameter logic [7:0] GAP_BYTE = 8'h4E
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] byte_in,
  input  logic       byte_sync,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       mfm_out,
  output logic       loaded,
  output logic       underrun
);

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       mfm_q, mfm_d;
  logic       loaded_q, loaded_d;
  logic       underrun_q, underrun_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_sync_q, hold_sync_d;
  logic       hold_full_q, hold_full_d;

  logic       load_edge;
  logic       accept;
  logic [2:0] bit_idx;
  logic       cur_bit;

  assign load_edge  = enable && (cnt_q == 4'd15);
  assign byte_ready = !hold_full_q || load_edge;
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    cnt_d       = cnt_q;
    data_d      = data_q;
    sync_d      = sync_q;
    prev_d      = prev_q;
    mfm_d       = mfm_q;
    loaded_d    = 1'b0;
    underrun_d  = underrun_q;
    hold_d      = hold_q;
    hold_sync_d = hold_sync_q;
    hold_full_d = hold_full_q;

    if (load_edge) begin
      cnt_d = 4'd0;
      if (hold_full_q) begin
        data_d   = hold_q;
        sync_d   = hold_sync_q;
        loaded_d = 1'b1;
      end else if (accept) begin
        data_d   = byte_in;
        sync_d   = byte_sync;
        loaded_d = 1'b1;
      end else begin
        data_d     = GAP_BYTE;
        sync_d     = 1'b0;
        underrun_d = 1'b1;
      end
    end else if (enable) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = 4'd15;
    end

    // Cell k of the byte belongs to bit 7-k/2; odd k is the data cell.
    bit_idx = 3'd7 - cnt_d[3:1];
    cur_bit = data_d[bit_idx];

    if (!enable) begin
      mfm_d  = 1'b0;
      prev_d = 1'b0;
    end else if (cnt_d[0]) begin
      mfm_d  = cur_bit;
      prev_d = cur_bit;
    end else begin
      mfm_d = !prev_q && !cur_bit && !(sync_d && bit_idx == 3'd2);
    end

    // The holding register drains on a load edge and refills on any accept that is not a bypass.
    if (load_edge && hold_full_q) hold_full_d = 1'b0;
    if (accept && !(load_edge && !hold_full_q)) begin
      hold_d      = byte_in;
      hold_sync_d = byte_sync;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk5) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      cnt_q       <= 4'd15;
      prev_q      <= 1'b0;
      mfm_q       <= 1'b0;
      loaded_q    <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      mfm_q       <= mfm_d;
      loaded_q    <= loaded_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      sync_q      <= sync_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only read once a valid/full flag says so.
  always_ff @(posedge clk5) begin
    data_q      <= data_d;
    hold_q      <= hold_d;
    hold_sync_q <= hold_sync_d;
  end

  assign mfm_out  = mfm_q;
  assign loaded   = loaded_q;
  assign underrun = underrun_q;

endmodule
